// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, CPU request size codes and the initiator state type.
// Imported by the memory master, its lane aligner and the bench.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    localparam logic [1:0] CPU_SIZE_BYTE    = 2'b00;
    localparam logic [1:0] CPU_SIZE_HALF    = 2'b01;
    localparam logic [1:0] CPU_SIZE_WORD    = 2'b10;
    localparam logic [1:0] CPU_SIZE_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } state_t;

    // Size 11 and any access not aligned to its own size never reach the bus.
    function automatic logic req_is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            CPU_SIZE_BYTE: ok = 1'b1;
            CPU_SIZE_HALF: ok = (addr_lo[0] == 1'b0);
            CPU_SIZE_WORD: ok = (addr_lo == 2'b00);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ahb_mem_master_if.sv
// AHB-Lite bus plus CPU load/store request/response bundle for ahb_mem_master.
// The master modport is the initiator's view; slave is the CPU/memory side.
interface ahb_mem_master_if;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        input  HRDATA, HREADY, HRESP,
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HMASTLOCK, HWDATA,
        output HRDATA, HREADY, HRESP,
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

endinterface

// File: rtl/ahb_lane_align.sv
// Combinational byte-lane steering: store data replication onto HWDATA and
// little-endian load extraction with optional sign extension.
module ahb_lane_align
    import ahb_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_hrdata,
    output logic [31:0] o_hwdata,
    output logic [31:0] o_rdata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_half = i_addr_lo[1] ? i_hrdata[31:16] : i_hrdata[15:0];

    always_comb begin
        case (i_size)
            CPU_SIZE_BYTE: o_hwdata = {4{i_wdata[7:0]}};
            CPU_SIZE_HALF: o_hwdata = {2{i_wdata[15:0]}};
            default:       o_hwdata = i_wdata;
        endcase
    end

    always_comb begin
        case (i_addr_lo)
            2'b00:   w_byte = i_hrdata[7:0];
            2'b01:   w_byte = i_hrdata[15:8];
            2'b10:   w_byte = i_hrdata[23:16];
            2'b11:   w_byte = i_hrdata[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    always_comb begin
        case (i_size)
            CPU_SIZE_BYTE: o_rdata = {{24{i_signed & w_byte[7]}}, w_byte};
            CPU_SIZE_HALF: o_rdata = {{16{i_signed & w_half[15]}}, w_half};
            default:       o_rdata = i_hrdata;
        endcase
    end

endmodule

// File: rtl/ahb_mem_master.sv
// Single-transfer AHB-Lite initiator: one CPU load/store at a time, run as a
// NONSEQ SINGLE transfer, with wait states and two-cycle ERROR handling.
module ahb_mem_master
    import ahb_pkg::*;
(
    input  logic             HCLK,
    input  logic             HRESET,
    ahb_mem_master_if.master bus
);

    state_t      r_state;
    logic        r_write;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic [31:0] r_haddr;
    logic [1:0]  r_htrans;
    logic        r_hwrite;
    logic [2:0]  r_hsize;
    logic [31:0] r_hwdata;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;
    logic        r_busy;

    logic [31:0] w_hwdata;
    logic [31:0] w_rdata;

    ahb_lane_align u_lane_align (
        .i_size    (r_size),
        .i_addr_lo (r_haddr[1:0]),
        .i_signed  (r_signed),
        .i_wdata   (r_wdata),
        .i_hrdata  (bus.HRDATA),
        .o_hwdata  (w_hwdata),
        .o_rdata   (w_rdata)
    );

    // Transfer FSM; every bus and response output is a register updated here.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state      <= ST_IDLE;
            r_write      <= 1'b0;
            r_size       <= CPU_SIZE_BYTE;
            r_signed     <= 1'b0;
            r_wdata      <= 32'h0000_0000;
            r_haddr      <= 32'h0000_0000;
            r_htrans     <= HTRANS_IDLE;
            r_hwrite     <= 1'b0;
            r_hsize      <= HSIZE_BYTE;
            r_hwdata     <= 32'h0000_0000;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0000_0000;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_write     <= bus.req_write;
                        r_size      <= bus.req_size;
                        r_signed    <= bus.req_signed;
                        r_wdata     <= bus.req_wdata;
                        if (req_is_legal(bus.req_size, bus.req_addr[1:0])) begin
                            r_state  <= ST_ADDR;
                            r_haddr  <= bus.req_addr;
                            r_htrans <= HTRANS_NONSEQ;
                            r_hwrite <= bus.req_write;
                            r_hsize  <= {1'b0, bus.req_size};
                        end else begin
                            // Rejected locally: the bus never sees this request.
                            r_state      <= ST_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= 32'h0000_0000;
                        end
                    end
                end
                ST_ADDR: begin
                    if (bus.HREADY) begin
                        r_state  <= ST_DATA;
                        r_htrans <= HTRANS_IDLE;
                        r_hwdata <= r_write ? w_hwdata : 32'h0000_0000;
                    end
                end
                ST_DATA: begin
                    // HREADY low covers both wait states and the first ERROR cycle.
                    if (bus.HREADY) begin
                        r_state      <= ST_RESP;
                        r_hwdata     <= 32'h0000_0000;
                        r_resp_valid <= 1'b1;
                        r_resp_err   <= bus.HRESP;
                        r_resp_rdata <= (bus.HRESP || r_write) ? 32'h0000_0000 : w_rdata;
                    end
                end
                ST_RESP: begin
                    r_state      <= ST_IDLE;
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= 32'h0000_0000;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_htrans     <= HTRANS_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.HADDR      = r_haddr;
    assign bus.HTRANS     = r_htrans;
    assign bus.HWRITE     = r_hwrite;
    assign bus.HSIZE      = r_hsize;
    assign bus.HBURST     = HBURST_SINGLE;
    assign bus.HPROT      = HPROT_DEFAULT;
    assign bus.HMASTLOCK  = 1'b0;
    assign bus.HWDATA     = r_hwdata;
    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.resp_err   = r_resp_err;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_ahb_mem_master.sv
// Randomized scoreboard bench for ahb_mem_master: a driver issues requests and
// plays the AHB slave, a monitor pops expected bus/response items and compares.
module tb_ahb_mem_master;
    import ahb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    ahb_mem_master_if bus ();

    ahb_mem_master dut (
        .HCLK   (clk),
        .HRESET (rst),
        .bus    (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          c0;
        int          lat;
    } resp_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  hsize;
        logic [31:0] hwdata;
        int          ns_len;
    } bus_exp_t;

    resp_exp_t rq[$];
    bus_exp_t  bq[$];
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model, straight from the byte-lane rules.
    function automatic logic m_legal(input logic [1:0] size, input logic [31:0] a);
        return (size == 2'd0) || (size == 2'd1 && a[0] == 1'b0) || (size == 2'd2 && a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] m_repl(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd0) return (d & 32'h0000_00FF) * 32'h0101_0101;
        if (size == 2'd1) return (d & 32'h0000_FFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] size, input logic [1:0] alo,
                                           input logic sgn, input logic [31:0] hr);
        logic [31:0] v;
        logic [31:0] mask;
        int bits;
        if (size == 2'd2) return hr;
        bits = (size == 2'd0) ? 8 : 16;
        mask = (32'h1 << bits) - 32'h1;
        v = (hr >> (32'd8 * alo)) & mask;
        if (sgn && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    // Monitor: checks address phases, data-phase write data and responses.
    initial begin : monitor
        bus_exp_t  cur_b;
        resp_exp_t e;
        logic have_b;
        logic in_ns;
        logic prev_rv;
        int ns_cnt;
        have_b = 1'b0; in_ns = 1'b0; prev_rv = 1'b0; ns_cnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_ns = 1'b0; prev_rv = 1'b0;
            end else begin
                if (bus.HTRANS == HTRANS_NONSEQ) begin
                    if (!in_ns) begin
                        chk("nonseq_expected", 32'(bq.size() != 0), 32'd1);
                        if (bq.size() != 0) begin
                            cur_b = bq.pop_front();
                            have_b = 1'b1;
                            chk("haddr", bus.HADDR, cur_b.addr);
                            chk("hwrite", 32'(bus.HWRITE), 32'(cur_b.write));
                            chk("hsize", 32'(bus.HSIZE), 32'(cur_b.hsize));
                        end
                        in_ns = 1'b1; ns_cnt = 1;
                    end else begin
                        ns_cnt++;
                    end
                end else begin
                    if (in_ns && have_b) chk("nonseq_len", ns_cnt, cur_b.ns_len);
                    in_ns = 1'b0;
                    if (have_b && bus.busy && !bus.resp_valid) begin
                        chk("data_haddr_hold", bus.HADDR, cur_b.addr);
                        if (cur_b.write) chk("hwdata", bus.HWDATA, cur_b.hwdata);
                    end
                end
                if (bus.resp_valid) begin
                    chk("resp_single_cycle", 32'(prev_rv), 32'd0);
                    chk("resp_expected", 32'(rq.size() != 0), 32'd1);
                    if (rq.size() != 0) begin
                        e = rq.pop_front();
                        chk("resp_rdata", bus.resp_rdata, e.rdata);
                        chk("resp_err", 32'(bus.resp_err), 32'(e.err));
                        chk("resp_latency", cyc - e.c0, e.lat);
                    end
                end
                prev_rv = bus.resp_valid;
            end
        end
    end

    task automatic wait_ready();
        int t;
        t = 0;
        while (!bus.req_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    // Issue one request and act as the slave for its address and data phases.
    task automatic run_txn(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int aw, input int dw, input logic er, input logic [31:0] hr);
        resp_exp_t e;
        bus_exp_t  b;
        logic legal;
        int k;
        int ph;
        wait_ready();
        legal   = m_legal(sz, a);
        e.c0    = cyc;
        e.err   = !legal || er;
        e.rdata = (!legal || er || w) ? 32'h0 : m_load(sz, a[1:0], sg, hr);
        e.lat   = legal ? (2 + aw + dw + (er ? 2 : 1)) : 1;
        rq.push_back(e);
        if (legal) begin
            b.addr = a; b.write = w; b.hsize = {1'b0, sz};
            b.hwdata = m_repl(sz, wd); b.ns_len = aw + 1;
            bq.push_back(b);
        end
        bus.req_valid = 1'b1; bus.req_write = w; bus.req_size = sz;
        bus.req_signed = sg; bus.req_addr = a; bus.req_wdata = wd;
        @(negedge clk);
        bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
        if (legal) begin
            k = 0; ph = 0;
            for (int t = 0; t < 60 && ph < 2; t++) begin
                bus.HRDATA = $urandom;
                bus.HRESP  = 1'b0;
                if (ph == 0) begin
                    if (bus.HTRANS == HTRANS_NONSEQ && k < aw) begin
                        bus.HREADY = 1'b0; k++;
                    end else if (bus.HTRANS == HTRANS_NONSEQ) begin
                        bus.HREADY = 1'b1; ph = 1; k = 0;
                    end else begin
                        bus.HREADY = 1'b1;
                    end
                end else begin
                    if (k < dw) begin
                        bus.HREADY = 1'b0;
                    end else if (er && k == dw) begin
                        bus.HREADY = 1'b0; bus.HRESP = 1'b1;
                    end else if (er) begin
                        bus.HREADY = 1'b1; bus.HRESP = 1'b1; ph = 2;
                    end else begin
                        bus.HREADY = 1'b1; bus.HRDATA = hr; ph = 2;
                    end
                    k++;
                end
                @(negedge clk);
            end
            bus.HREADY = 1'b1; bus.HRESP = 1'b0;
            chk("slave_phase_done", ph, 2);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_haddr"}, bus.HADDR, 32'h0);
        chk({tag, "_htrans"}, 32'(bus.HTRANS), 32'(HTRANS_IDLE));
        chk({tag, "_hwrite"}, 32'(bus.HWRITE), 32'd0);
        chk({tag, "_hsize"}, 32'(bus.HSIZE), 32'd0);
        chk({tag, "_hwdata"}, bus.HWDATA, 32'h0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_resp_rdata"}, bus.resp_rdata, 32'h0);
        chk({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Abandon a store in its data phase with an asynchronous reset pulse.
    task automatic reset_mid();
        bus_exp_t b;
        wait_ready();
        b.addr = 32'h2000_0008; b.write = 1'b1; b.hsize = HSIZE_WORD;
        b.hwdata = 32'hCAFE_F00D; b.ns_len = 1;
        bq.push_back(b);
        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd2;
        bus.req_signed = 1'b0; bus.req_addr = 32'h2000_0008; bus.req_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("rst_mid_nonseq", 32'(bus.HTRANS), 32'(HTRANS_NONSEQ));
        bus.HREADY = 1'b1;
        @(negedge clk);
        bus.HREADY = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_data", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0; bus.HREADY = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [1:0] sz;
        logic [31:0] a;
        int r;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'd0;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
        bus.HREADY = 1'b1; bus.HRESP = 1'b0; bus.HRDATA = 32'h0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        chk("reset_hburst", 32'(bus.HBURST), 32'd0);
        chk("reset_hprot", 32'(bus.HPROT), 32'd3);
        chk("reset_hmastlock", 32'(bus.HMASTLOCK), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 0, 0, 1'b0, 32'hDEAD_BEEF);
        run_txn(1'b0, 2'd0, 1'b1, 32'h2000_0003, 32'h0, 0, 0, 1'b0, 32'h8000_0000);
        run_txn(1'b0, 2'd0, 1'b0, 32'h2000_0003, 32'h0, 0, 0, 1'b0, 32'h8000_0000);
        run_txn(1'b1, 2'd1, 1'b0, 32'h3000_0002, 32'h0000_1234, 0, 2, 1'b0, 32'h0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h4000_0000, 32'h0, 0, 0, 1'b1, 32'h1111_1111);
        run_txn(1'b0, 2'd2, 1'b0, 32'h5000_0002, 32'h0, 0, 0, 1'b0, 32'h0);
        run_txn(1'b0, 2'd1, 1'b1, 32'h6000_0002, 32'h0, 2, 1, 1'b0, 32'h8001_7FFF);
        reset_mid();
        run_txn(1'b0, 2'd2, 1'b0, 32'h1000_0004, 32'h0, 0, 0, 1'b0, 32'h0BAD_F00D);

        for (int i = 0; i < 250; i++) begin
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            run_txn(1'($urandom), sz, 1'($urandom), a, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2),
                    ($urandom_range(0, 5) == 0), $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int t = 0; t < 100 && (rq.size() != 0 || !bus.req_ready); t++) @(negedge clk);
        chk("drain_resp_queue", rq.size(), 32'd0);
        chk("drain_bus_queue", bq.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
